// File: rtl/vga_sync_monitor_pkg.sv
// rtl/vga_sync_monitor_pkg.sv - VGA 640x480@60 timing constants, monitor FSM states and counter helper
package vga_sync_monitor_pkg;

    localparam int H_VIS       = 640;
    localparam int H_FP        = 16;
    localparam int H_SYNC      = 96;
    localparam int H_BP        = 48;
    localparam int H_TOTAL     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_VIS       = 480;
    localparam int V_FP        = 10;
    localparam int V_SYNC      = 2;
    localparam int V_BP        = 33;
    localparam int V_TOTAL     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int LOCK_FRAMES = 2;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } mon_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vga_sync_monitor_sync_edge_meter.sv
// rtl/vga_sync_monitor_sync_edge_meter.sv - sync edge detector with saturating period/pulse-width meter
module sync_edge_meter #(
    parameter int TOTAL = 800,
    parameter int PULSE = 96
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_i,
    input  logic tick_i,
    input  logic hunt_i,
    output logic fall_o,
    output logic len_err_o,
    output logic pw_err_o
);
    import vga_sync_monitor_pkg::*;

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] PULSE_C = CNT_W'(PULSE);

    logic             sync_q;
    logic             armed_q;
    logic             armed_d;
    logic             rise;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] pw_q, pw_d;

    assign fall_o = sync_q & ~sync_i;
    assign rise   = ~sync_q & sync_i;

    // The falling edge itself is the first counted unit of the new period and pulse.
    always_comb begin
        len_d = len_q;
        pw_d  = pw_q;
        if (fall_o) begin
            len_d = {{(CNT_W-1){1'b0}}, tick_i};
            pw_d  = {{(CNT_W-1){1'b0}}, tick_i};
        end else begin
            if (tick_i) len_d = sat_inc(len_q);
            if (tick_i && !sync_i) pw_d = sat_inc(pw_q);
        end
    end

    // Arming survives only outside HUNT, so checks need a start edge seen since the last hunt.
    assign armed_d   = fall_o | (armed_q & ~hunt_i);
    assign len_err_o = fall_o & armed_q & (len_q != TOTAL_C);
    assign pw_err_o  = rise & armed_q & (pw_q != PULSE_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 1'b1;
            armed_q <= 1'b0;
            len_q   <= '0;
            pw_q    <= '0;
        end else begin
            sync_q  <= sync_i;
            armed_q <= armed_d;
            len_q   <= len_d;
            pw_q    <= pw_d;
        end
    end

endmodule

// File: rtl/vga_sync_monitor.sv
// rtl/vga_sync_monitor.sv - VGA receive-side sync monitor: position recovery, timing lock, frame checksum
module vga_sync_monitor #(
    parameter int H_VIS       = vga_sync_monitor_pkg::H_VIS,
    parameter int H_FP        = vga_sync_monitor_pkg::H_FP,
    parameter int H_SYNC      = vga_sync_monitor_pkg::H_SYNC,
    parameter int H_BP        = vga_sync_monitor_pkg::H_BP,
    parameter int V_VIS       = vga_sync_monitor_pkg::V_VIS,
    parameter int V_FP        = vga_sync_monitor_pkg::V_FP,
    parameter int V_SYNC      = vga_sync_monitor_pkg::V_SYNC,
    parameter int V_BP        = vga_sync_monitor_pkg::V_BP,
    parameter int LOCK_FRAMES = vga_sync_monitor_pkg::LOCK_FRAMES
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic [15:0] rgb,
    input  logic        err_clr,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        de,
    output logic        locked,
    output logic [15:0] frame_sum,
    output logic        frame_sum_valid,
    output logic [7:0]  frame_cnt,
    output logic        h_len_err,
    output logic        h_pw_err,
    output logic        v_len_err,
    output logic        v_pw_err
);
    import vga_sync_monitor_pkg::*;

    localparam int MY_H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int MY_V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LOAD  = 10'(H_VIS + H_FP);
    localparam logic [9:0] V_LOAD  = 10'(V_VIS + V_FP);
    localparam logic [9:0] H_LAST  = 10'(MY_H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(MY_V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C = 10'(V_VIS);
    localparam logic [3:0] GOOD_LAST = 4'(LOCK_FRAMES - 1);

    mon_state_e  state_q;
    logic [3:0]  good_q;
    logic        locked_q;
    logic        hunt;
    logic        hs_fall, vs_fall;
    logic        h_len_new, h_pw_new, v_len_new, v_pw_new;
    logic        new_err;
    logic [9:0]  hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic        h_wrap;
    logic        win_d;
    logic        de_q;
    logic [15:0] acc_q;
    logic [15:0] frame_sum_q;
    logic        fsv_q;
    logic [7:0]  frame_cnt_q;
    logic        h_len_err_q, h_pw_err_q, v_len_err_q, v_pw_err_q;

    assign hunt = (state_q == HUNT);

    sync_edge_meter #(.TOTAL(MY_H_TOTAL), .PULSE(H_SYNC)) u_h_meter (
        .clk      (clk),
        .rst_n    (clr),
        .sync_i   (vga_hs),
        .tick_i   (1'b1),
        .hunt_i   (hunt),
        .fall_o   (hs_fall),
        .len_err_o(h_len_new),
        .pw_err_o (h_pw_new)
    );

    // Vertical measurements are in lines, so the tick is the horizontal sync edge.
    sync_edge_meter #(.TOTAL(MY_V_TOTAL), .PULSE(V_SYNC)) u_v_meter (
        .clk      (clk),
        .rst_n    (clr),
        .sync_i   (vga_vs),
        .tick_i   (hs_fall),
        .hunt_i   (hunt),
        .fall_o   (vs_fall),
        .len_err_o(v_len_new),
        .pw_err_o (v_pw_new)
    );

    assign new_err = h_len_new | h_pw_new | v_len_new | v_pw_new;

    // Position of the sample being taken this cycle.
    always_comb begin
        h_wrap = 1'b0;
        hpos_d = hpos_q + 10'd1;
        if (hs_fall) begin
            hpos_d = H_LOAD;
        end else if (hpos_q == H_LAST) begin
            hpos_d = '0;
            h_wrap = 1'b1;
        end
        vpos_d = vpos_q;
        if (vs_fall) begin
            vpos_d = V_LOAD;
        end else if (h_wrap) begin
            vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
        end
    end

    assign win_d = (hpos_d < H_VIS_C) & (vpos_d < V_VIS_C);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= HUNT;
            good_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (vs_fall) begin
                        state_q <= ACQUIRE;
                        good_q  <= '0;
                    end
                end
                ACQUIRE: begin
                    if (new_err) begin
                        state_q <= HUNT;
                        good_q  <= '0;
                    end else if (vs_fall) begin
                        good_q <= good_q + 4'd1;
                        if (good_q == GOOD_LAST) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (new_err) begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                        good_q   <= '0;
                    end
                end
                default: begin
                    state_q  <= HUNT;
                    locked_q <= 1'b0;
                    good_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hpos_q      <= '0;
            vpos_q      <= '0;
            de_q        <= 1'b0;
            acc_q       <= '0;
            frame_sum_q <= '0;
            fsv_q       <= 1'b0;
            frame_cnt_q <= '0;
            h_len_err_q <= 1'b0;
            h_pw_err_q  <= 1'b0;
            v_len_err_q <= 1'b0;
            v_pw_err_q  <= 1'b0;
        end else begin
            hpos_q <= hpos_d;
            vpos_q <= vpos_d;
            de_q   <= locked_q & ~new_err & win_d;

            h_len_err_q <= (h_len_err_q & ~err_clr) | h_len_new;
            h_pw_err_q  <= (h_pw_err_q  & ~err_clr) | h_pw_new;
            v_len_err_q <= (v_len_err_q & ~err_clr) | v_len_new;
            v_pw_err_q  <= (v_pw_err_q  & ~err_clr) | v_pw_new;

            // A frame ending on the vs_fall that left HUNT was only partly summed, so it is dropped.
            fsv_q <= 1'b0;
            if (vs_fall) begin
                acc_q <= '0;
                if (!hunt) begin
                    frame_sum_q <= acc_q;
                    fsv_q       <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + 8'd1;
                end
            end else if (!hunt && win_d) begin
                acc_q <= acc_q + rgb;
            end
        end
    end

    assign x               = hpos_q;
    assign y               = vpos_q;
    assign de              = de_q;
    assign locked          = locked_q;
    assign frame_sum       = frame_sum_q;
    assign frame_sum_valid = fsv_q;
    assign frame_cnt       = frame_cnt_q;
    assign h_len_err       = h_len_err_q;
    assign h_pw_err        = h_pw_err_q;
    assign v_len_err       = v_len_err_q;
    assign v_pw_err        = v_pw_err_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// tb/tb_vga_sync_monitor.sv - directed bench for vga_sync_monitor on a reduced 16x10 raster
module tb_vga_sync_monitor;

    localparam int TB_HV = 8;
    localparam int TB_HF = 2;
    localparam int TB_HS = 3;
    localparam int TB_HB = 3;
    localparam int TB_VV = 4;
    localparam int TB_VF = 2;
    localparam int TB_VS = 2;
    localparam int TB_VB = 2;
    localparam int TB_HT = TB_HV + TB_HF + TB_HS + TB_HB;
    localparam int TB_VT = TB_VV + TB_VF + TB_VS + TB_VB;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic [15:0] rgb = '0;
    logic        err_clr = 1'b0;
    logic [9:0]  x, y;
    logic        de, locked, frame_sum_valid;
    logic [15:0] frame_sum;
    logic [7:0]  frame_cnt;
    logic        h_len_err, h_pw_err, v_len_err, v_pw_err;

    vga_sync_monitor #(
        .H_VIS(TB_HV), .H_FP(TB_HF), .H_SYNC(TB_HS), .H_BP(TB_HB),
        .V_VIS(TB_VV), .V_FP(TB_VF), .V_SYNC(TB_VS), .V_BP(TB_VB),
        .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .clr(clr), .vga_hs(vga_hs), .vga_vs(vga_vs), .rgb(rgb),
        .err_clr(err_clr), .x(x), .y(y), .de(de), .locked(locked),
        .frame_sum(frame_sum), .frame_sum_valid(frame_sum_valid), .frame_cnt(frame_cnt),
        .h_len_err(h_len_err), .h_pw_err(h_pw_err), .v_len_err(v_len_err), .v_pw_err(v_pw_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int vsf_cnt = 0;
    int lock_at = 0;
    int valid_cnt = 0;
    int double_pulse = 0;
    int base = 0;
    logic prev_valid = 1'b0;
    logic prev_locked = 1'b0;
    logic prev_hlen = 1'b0;
    logic prev_vs_drv = 1'b1;
    logic lock_at_err = 1'b1;
    logic seen_de = 1'b0;
    logic [15:0] last_sum = '0;
    logic [9:0] first_x = '1, first_y = '1, last_x = '1, last_y = '1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one sample, then observe the registered outputs describing it.
    task automatic tick(input logic hs, input logic vs, input logic [15:0] px, input logic ec);
        vga_hs = hs;
        vga_vs = vs;
        rgb = px;
        err_clr = ec;
        if (prev_vs_drv && !vs) vsf_cnt++;
        prev_vs_drv = vs;
        @(posedge clk);
        #1;
        if (frame_sum_valid) begin
            valid_cnt++;
            last_sum = frame_sum;
            if (prev_valid) double_pulse++;
        end
        prev_valid = frame_sum_valid;
        if (locked && !prev_locked) lock_at = vsf_cnt;
        prev_locked = locked;
        if (h_len_err && !prev_hlen) lock_at_err = locked;
        prev_hlen = h_len_err;
        if (de) begin
            if (!seen_de) begin
                first_x = x;
                first_y = y;
                seen_de = 1'b1;
            end
            last_x = x;
            last_y = y;
        end
    endtask

    task automatic gen_frame(input int pat, input int v_start, input int v_stop,
                             input int stretch_line, input int hs_short_line,
                             input int vs_lines, input int clr_line, input int clr_h);
        int h_end;
        for (int v = v_start; v < v_stop; v++) begin
            h_end = (v == stretch_line) ? TB_HT + 1 : TB_HT;
            for (int h = 0; h < h_end; h++) begin
                logic hs, vs;
                logic [15:0] px;
                hs = !(h >= TB_HV + TB_HF && h < TB_HV + TB_HF + ((v == hs_short_line) ? TB_HS - 1 : TB_HS));
                vs = !(v >= TB_VV + TB_VF && v < TB_VV + TB_VF + vs_lines);
                px = '0;
                if (h < TB_HV && v < TB_VV) begin
                    case (pat)
                        1: px = 16'h001F;
                        2: px = 16'(h);
                        3: px = 16'hFFFF;
                        default: px = '0;
                    endcase
                end
                tick(hs, vs, px, (v == clr_line) && (h == clr_h));
            end
        end
    endtask

    task automatic frame(input int pat);
        gen_frame(pat, 0, TB_VT, -1, -1, TB_VS, -1, -1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_de", de, 0);
        chk("rst_locked", locked, 0);
        chk("rst_sum", frame_sum, 0);
        chk("rst_valid", frame_sum_valid, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_errs", {h_len_err, h_pw_err, v_len_err, v_pw_err}, 0);
        clr = 1'b1;

        repeat (4) frame(1);
        chk("lock_at_vsf", lock_at, 3);
        chk("nominal_errs", {h_len_err, h_pw_err, v_len_err, v_pw_err}, 0);
        chk("nominal_cnt", frame_cnt, 3);
        chk("nominal_valids", valid_cnt, 3);
        chk("valid_single_cycle", double_pulse, 0);
        chk("sum_const_1f", last_sum, 16'h03E0);

        seen_de = 1'b0;
        frame(2);
        chk("first_de_x", first_x, 0);
        chk("first_de_y", first_y, 0);
        chk("last_de_x", last_x, TB_HV - 1);
        chk("last_de_y", last_y, TB_VV - 1);
        chk("sum_gradient", last_sum, 16'h0070);
        chk("cnt_f5", frame_cnt, 4);

        frame(3);
        chk("sum_wrap_ffff", last_sum, 16'hFFE0);
        chk("cnt_f6", frame_cnt, 5);

        gen_frame(0, 0, TB_VT, 1, -1, TB_VS, -1, -1);
        chk("h_len_err_set", h_len_err, 1);
        chk("unlock_with_err", lock_at_err, 0);
        chk("other_errs_f7", {h_pw_err, v_len_err, v_pw_err}, 0);
        chk("cnt_no_update_hunt", frame_cnt, 5);

        lock_at = 0;
        gen_frame(0, 0, TB_VT, -1, -1, TB_VS, 0, 0);
        chk("h_len_err_cleared", h_len_err, 0);
        chk("cnt_f8", frame_cnt, 6);
        frame(1);
        chk("relock_at_vsf", lock_at, 9);
        chk("relocked", locked, 1);
        chk("cnt_f9", frame_cnt, 7);

        gen_frame(0, 0, TB_VT, -1, 2, TB_VS, -1, -1);
        chk("h_pw_err_set", h_pw_err, 1);
        chk("h_len_err_f10", h_len_err, 0);
        chk("unlock_pw", locked, 0);

        gen_frame(0, 0, TB_VT, -1, -1, TB_VS + 1, 0, 0);
        chk("h_pw_err_cleared", h_pw_err, 0);
        chk("v_pw_err_set", v_pw_err, 1);
        chk("v_len_err_f11", v_len_err, 0);
        chk("cnt_f11", frame_cnt, 8);

        frame(0);
        gen_frame(0, 0, TB_VT, 1, -1, TB_VS, 2, TB_HV + TB_HF);
        chk("err_beats_clr", h_len_err, 1);
        chk("clr_other_flag", v_pw_err, 0);

        frame(1);
        frame(1);
        chk("locked_pre_reset", locked, 1);
        chk("cnt_pre_reset", frame_cnt, 10);

        gen_frame(1, 0, 2, -1, -1, TB_VS, -1, -1);
        clr = 1'b0;
        #1;
        chk("midrst_xy", {x, y}, 0);
        chk("midrst_flags", {de, locked, frame_sum_valid}, 0);
        chk("midrst_sum_cnt", {frame_sum, frame_cnt}, 0);
        chk("midrst_errs", {h_len_err, h_pw_err, v_len_err, v_pw_err}, 0);
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        base = vsf_cnt;
        lock_at = 0;

        gen_frame(1, 2, TB_VT, -1, -1, TB_VS, -1, -1);
        frame(1);
        chk("no_lock_2nd_vsf", locked, 0);
        frame(1);
        chk("lock_3rd_vsf", lock_at - base, 3);
        chk("cnt_after_rst", frame_cnt, 2);
        chk("sum_after_rst", frame_sum, 16'h03E0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
